// File: rtl/perf_report_tx.sv
// Performance report transmitter: snapshots cycle_count at the final PC (or on send_req)
// and sends "C=<hex>\r\n" over a UART line. Define PERF_TX_PARITY_EN for an even-parity bit.
module perf_report_tx #(
    parameter logic [15:0] FINAL_PC       = 16'hFFFF,
    parameter int          CLKS_PER_BIT   = 434,
    parameter int          NUM_HEX_DIGITS = 8
) (
    input  logic        cpu_clk,
    input  logic        resetN,
    input  logic [15:0] pc,
    input  logic [31:0] cycle_count,
    input  logic        send_req,
    output logic        tx,
    output logic        busy,
    output logic        done
);

`ifdef PERF_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int          MSG_LEN  = NUM_HEX_DIGITS + 4;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  CHR_LAST = 4'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  chr_q, chr_d;
    logic [31:0] snap_q, snap_d;
    logic        fired_q, fired_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        pc_hit;
    logic        trig;
    logic        bit_end;
    logic [7:0]  cur_byte;
    logic [3:0]  nib;
    int          sh;

    assign pc_hit  = (pc == FINAL_PC);
    assign bit_end = (cnt_q == BIT_LAST);
    // The pc match only fires once per reset; send_req re-arms from IDLE or DONE.
    assign trig    = ((state_q == S_IDLE) && ((pc_hit && !fired_q) || send_req)) ||
                     ((state_q == S_DONE) && send_req);

    // Character currently being shifted out, from the frozen snapshot.
    always_comb begin
        cur_byte = 8'h0A;
        nib      = 4'h0;
        sh       = 0;
        if (chr_q == 4'd0) begin
            cur_byte = 8'h43;
        end else if (chr_q == 4'd1) begin
            cur_byte = 8'h3D;
        end else if (int'(chr_q) < NUM_HEX_DIGITS + 2) begin
            sh       = (NUM_HEX_DIGITS + 1 - int'(chr_q)) * 4;
            nib      = 4'(snap_q >> sh);
            cur_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (int'(chr_q) == NUM_HEX_DIGITS + 2) begin
            cur_byte = 8'h0D;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        chr_d   = chr_q;
        snap_d  = snap_q;
        fired_d = fired_q | pc_hit;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (trig) begin
                    state_d = S_START;
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    chr_d   = 4'd0;
                    snap_d  = cycle_count;
                end
            end
            default: begin
                cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
                if (bit_end) begin
                    case (state_q)
                        S_START: begin
                            state_d = S_DATA;
                            bit_d   = 3'd0;
                        end
                        S_DATA: begin
                            if (bit_q == 3'd7)
                                state_d = PARITY_EN ? S_PARITY : S_STOP;
                            else
                                bit_d = bit_q + 3'd1;
                        end
                        S_PARITY: state_d = S_STOP;
                        S_STOP: begin
                            if (chr_q < CHR_LAST) begin
                                state_d = S_START;
                                chr_d   = chr_q + 4'd1;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_START:  begin tx_d = 1'b0;            busy_d = 1'b1; end
            S_DATA:   begin tx_d = cur_byte[bit_d]; busy_d = 1'b1; end
            S_PARITY: begin tx_d = ^cur_byte;       busy_d = 1'b1; end
            S_STOP:   begin tx_d = 1'b1;            busy_d = 1'b1; end
            S_DONE:   done_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            chr_q   <= 4'd0;
            snap_q  <= 32'd0;
            fired_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            chr_q   <= chr_d;
            snap_q  <= snap_d;
            fired_q <= fired_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_perf_report_tx.sv
// Directed bench for perf_report_tx: UART decode of each message plus timing and corner sequences.
module tb_perf_report_tx;

`ifdef PERF_TX_PARITY_EN
    localparam int BB = 11;
`else
    localparam int BB = 10;
`endif
    localparam int CPB = 4;

    logic        cpu_clk = 1'b0;
    logic        resetN  = 1'b0;
    logic [15:0] pc = 16'h0, pc3 = 16'h0;
    logic [31:0] cc = 32'h0, cc3 = 32'h0;
    logic        send_req = 1'b0, sr3 = 1'b0;
    logic        tx, busy, done, tx3, busy3, done3;

    int tests = 0, fails = 0, cyc = 0;

    always #5 cpu_clk = ~cpu_clk;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    perf_report_tx #(.FINAL_PC(16'h0040), .CLKS_PER_BIT(CPB), .NUM_HEX_DIGITS(8)) u_dut (
        .cpu_clk(cpu_clk), .resetN(resetN), .pc(pc), .cycle_count(cc),
        .send_req(send_req), .tx(tx), .busy(busy), .done(done));

    perf_report_tx #(.FINAL_PC(16'h0040), .CLKS_PER_BIT(CPB), .NUM_HEX_DIGITS(3)) u_dut3 (
        .cpu_clk(cpu_clk), .resetN(resetN), .pc(pc3), .cycle_count(cc3),
        .send_req(sr3), .tx(tx3), .busy(busy3), .done(done3));

    typedef struct {
        logic [31:0] cc;
        string       exp;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
        end
    endtask

    function automatic logic txs(input bit sel);
        return sel ? tx3 : tx;
    endfunction

    function automatic logic dns(input bit sel);
        return sel ? done3 : done;
    endfunction

    // Decode nbytes UART characters; must be entered at a negedge at or before the first start bit.
    task automatic rx(input bit sel, input int nbytes, output string s);
        logic [7:0] b;
        int k;
        s = "";
        for (int n = 0; n < nbytes; n++) begin
            k = 0;
            while (txs(sel) !== 1'b0 && k < 2000) begin
                @(negedge cpu_clk);
                k++;
            end
            if (k >= 2000) begin
                chk("rx_start_timeout", 32'(k), 32'd0);
                return;
            end
            repeat (CPB / 2) @(negedge cpu_clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge cpu_clk);
                b[i] = txs(sel);
            end
`ifdef PERF_TX_PARITY_EN
            repeat (CPB) @(negedge cpu_clk);
            chk("parity", {31'd0, txs(sel)}, {31'd0, ^b});
`endif
            repeat (CPB) @(negedge cpu_clk);
            if (txs(sel) !== 1'b1) chk("stop_bit", {31'd0, txs(sel)}, 32'd1);
            if (b == 8'h0D)      s = {s, "<CR>"};
            else if (b == 8'h0A) s = {s, "<LF>"};
            else                 s = $sformatf("%s%c", s, b);
        end
    endtask

    task automatic wait_done(input bit sel, output int t);
        int k = 0;
        while (dns(sel) !== 1'b1 && k < 100) begin
            @(negedge cpu_clk);
            k++;
        end
        if (k >= 100) chk("done_timeout", 32'(k), 32'd0);
        t = cyc;
    endtask

    task automatic quiet(input string nm, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge cpu_clk);
            cc = cc + 32'd7;
            if (tx !== 1'b1 || done !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    initial begin
        string s;
        int t0, t1;

        vt[0] = '{32'h0000001F, "C=0000001F<CR><LF>"};
        vt[1] = '{32'h00000000, "C=00000000<CR><LF>"};
        vt[2] = '{32'hFFFFFFFF, "C=FFFFFFFF<CR><LF>"};
        vt[3] = '{32'h9A5F0E71, "C=9A5F0E71<CR><LF>"};

        repeat (3) @(negedge cpu_clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        resetN = 1'b1;
        repeat (2) @(negedge cpu_clk);
        chk("idle_tx", {31'd0, tx}, 32'd1);

        // Three-digit instance.
        cc3 = 32'h12345FA0;
        pc3 = 16'h0040;
        @(negedge cpu_clk);
        pc3 = 16'h0;
        chk("d3_tx_fall", {31'd0, tx3}, 32'd0);
        t0 = cyc;
        rx(1'b1, 7, s);
        chk_s("d3_msg", s, "C=FA0<CR><LF>");
        wait_done(1'b1, t1);
        chk("d3_frame_cycles", 32'(t1 - t0), 32'(7 * BB * CPB));

        // Main pc-match message.
        cc = 32'h00ABCDEF;
        pc = 16'h0040;
        @(negedge cpu_clk);
        cc = 32'h55555555;
        chk("tx_fall_after_match", {31'd0, tx}, 32'd0);
        chk("busy_after_match", {31'd0, busy}, 32'd1);
        t0 = cyc;
        rx(1'b0, 12, s);
        chk_s("msg_pc_match", s, "C=00ABCDEF<CR><LF>");
        chk("done_low_in_stop", {31'd0, done}, 32'd0);
        wait_done(1'b0, t1);
        chk("frame_cycles", 32'(t1 - t0), 32'(12 * BB * CPB));

        // pc still at FINAL_PC: no retrigger from DONE.
        quiet("no_retrigger_1000", 1000);

        // send_req mid-message is dropped.
        cc = 32'h11111111;
        send_req = 1'b1;
        @(negedge cpu_clk);
        send_req = 1'b0;
        fork
            rx(1'b0, 12, s);
            begin
                repeat (5 * BB * CPB + 10) @(negedge cpu_clk);
                cc = 32'h77777777;
                send_req = 1'b1;
                @(negedge cpu_clk);
                send_req = 1'b0;
            end
        join
        chk_s("msg_busy_req", s, "C=11111111<CR><LF>");
        wait_done(1'b0, t1);
        quiet("no_queued_msg", 200);

        // Table of resends from DONE.
        for (int i = 0; i < 4; i++) begin
            cc = vt[i].cc;
            send_req = 1'b1;
            @(negedge cpu_clk);
            send_req = 1'b0;
            chk($sformatf("v%0d_done_clr", i), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d_tx_fall", i), {31'd0, tx}, 32'd0);
            rx(1'b0, 12, s);
            chk_s($sformatf("v%0d_msg", i), s, vt[i].exp);
            wait_done(1'b0, t1);
            chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
        end

        // Asynchronous reset mid-DATA of byte 2, then pc match restarts from 'C'.
        cc = 32'h22222222;
        send_req = 1'b1;
        @(negedge cpu_clk);
        send_req = 1'b0;
        repeat (2 * BB * CPB + 10) @(negedge cpu_clk);
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        resetN = 1'b0;
        #1;
        chk("arst_tx", {31'd0, tx}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        cc = 32'h0BADF00D;
        @(negedge cpu_clk);
        resetN = 1'b1;
        @(negedge cpu_clk);
        chk("rst_retrigger_fall", {31'd0, tx}, 32'd0);
        rx(1'b0, 12, s);
        chk_s("msg_after_reset", s, "C=0BADF00D<CR><LF>");
        wait_done(1'b0, t1);

        // Simultaneous pc match and send_req from IDLE.
        pc = 16'h0;
        resetN = 1'b0;
        @(negedge cpu_clk);
        resetN = 1'b1;
        @(negedge cpu_clk);
        cc = 32'h00C0FFEE;
        pc = 16'h0040;
        send_req = 1'b1;
        @(negedge cpu_clk);
        send_req = 1'b0;
        chk("both_tx_fall", {31'd0, tx}, 32'd0);
        rx(1'b0, 12, s);
        chk_s("msg_both", s, "C=00C0FFEE<CR><LF>");
        wait_done(1'b0, t1);
        chk("fired_set", {31'd0, u_dut.fired_q}, 32'd1);
        quiet("single_msg_both", 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
